// File: rtl/sdram_port_pkg.sv
// Shared types for the toggle req/ack BRAM port responder.
package sdram_port_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } port_state_t;

    localparam logic [1:0] DS_NONE = 2'b00;
    localparam logic [1:0] DS_LO   = 2'b01;
    localparam logic [1:0] DS_HI   = 2'b10;
    localparam logic [1:0] DS_BOTH = 2'b11;

    // Sum of the byte lanes selected by en, zero-extended to 16 bits.
    function automatic logic [15:0] lane_sum(input logic [1:0] en, input logic [15:0] d);
        logic [15:0] lo;
        logic [15:0] hi;
        lo = ((en & DS_LO) != DS_NONE) ? {8'h00, d[7:0]}  : 16'h0000;
        hi = ((en & DS_HI) != DS_NONE) ? {8'h00, d[15:8]} : 16'h0000;
        return lo + hi;
    endfunction

endpackage

// File: rtl/sdram_port_responder.sv
// Responder end of the toggle req/ack memory port, backed by a synchronous BRAM.
// One byte-masked 16-bit read or write per request; ack toggles LATENCY cycles after ISSUE.
// Optional feature macro SDRAM_PORT_CSUM_EN adds a running byte checksum of all writes.
module sdram_port_responder
    import sdram_port_pkg::*;
#(
    parameter int AW      = 15,
    parameter int LATENCY = 2
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          port_req,
    output logic          port_ack,
    input  logic [AW-1:0] port_a,
    input  logic [1:0]    port_ds,
    input  logic          port_we,
    input  logic [15:0]   port_d,
    output logic [15:0]   port_q,
    output logic [AW-1:0] mem_addr,
    output logic [1:0]    mem_we,
    output logic [15:0]   mem_d,
    input  logic [15:0]   mem_q,
`ifdef SDRAM_PORT_CSUM_EN
    input  logic          csum_clr,
    output logic [15:0]   csum,
`endif
    output logic          err_overrun
);

    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    port_state_t   state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          we_q, we_d;
    logic          req_lvl_q, req_lvl_d;
    // Last req level this responder has consumed; a change of port_req away
    // from it is a new request. Toggles absorbed while busy are consumed at
    // completion so a double toggle does not launch a phantom access.
    logic          seen_q, seen_d;
    logic          ack_q, ack_d;
    logic [15:0]   rdata_q, rdata_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [1:0]    mem_we_q, mem_we_d;
    logic [15:0]   wdata_q, wdata_d;
    logic          err_q, err_d;
`ifdef SDRAM_PORT_CSUM_EN
    logic [15:0]   csum_q, csum_d;
`endif

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic: IDLE -> ISSUE on a pending toggle, one ISSUE cycle, WAIT until the counter expires.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (port_req != seen_q) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (cnt_q == 4'd0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output/datapath next values; the BRAM command is registered at capture so it is live during ISSUE.
    always_comb begin
        cnt_d     = cnt_q;
        we_d      = we_q;
        req_lvl_d = req_lvl_q;
        seen_d    = seen_q;
        ack_d     = ack_q;
        rdata_d   = rdata_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        mem_we_d  = DS_NONE;
        err_d     = err_q;
        unique case (state_q)
            IDLE: begin
                if (port_req != seen_q) begin
                    addr_d    = port_a;
                    wdata_d   = port_d;
                    mem_we_d  = port_we ? port_ds : DS_NONE;
                    we_d      = port_we;
                    req_lvl_d = port_req;
                    seen_d    = port_req;
                end
            end
            ISSUE: cnt_d = CNT_LOAD;
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    ack_d  = req_lvl_q;
                    seen_d = port_req;
                    if (!we_q) rdata_d = mem_q;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: ;
        endcase
        if ((state_q != IDLE) && (port_req != req_lvl_q)) err_d = 1'b1;
    end

`ifdef SDRAM_PORT_CSUM_EN
    // Checksum next value: clear wins over the ISSUE-cycle add of the enabled write bytes.
    always_comb begin
        csum_d = csum_q;
        if (csum_clr)              csum_d = 16'h0000;
        else if (state_q == ISSUE) csum_d = csum_q + lane_sum(mem_we_q, wdata_q);
    end

    // Checksum register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) csum_q <= 16'h0000;
        else          csum_q <= csum_d;
    end

    assign csum = csum_q;
`endif

    // Datapath and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q     <= 4'd0;
            we_q      <= 1'b0;
            req_lvl_q <= 1'b0;
            seen_q    <= 1'b0;
            ack_q     <= 1'b0;
            rdata_q   <= 16'h0000;
            addr_q    <= '0;
            mem_we_q  <= DS_NONE;
            wdata_q   <= 16'h0000;
            err_q     <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            we_q      <= we_d;
            req_lvl_q <= req_lvl_d;
            seen_q    <= seen_d;
            ack_q     <= ack_d;
            rdata_q   <= rdata_d;
            addr_q    <= addr_d;
            mem_we_q  <= mem_we_d;
            wdata_q   <= wdata_d;
            err_q     <= err_d;
        end
    end

    assign port_ack    = ack_q;
    assign port_q      = rdata_q;
    assign mem_addr    = addr_q;
    assign mem_we      = mem_we_q;
    assign mem_d       = wdata_q;
    assign err_overrun = err_q;

endmodule
